// File: rtl/crop_window_ctrl_if.sv
// Pixel stream, control and result bundle for crop_window_ctrl.
// The slave side is the measurement block; the master side is the capture stream and its controller.
interface crop_window_ctrl_if;
  logic        iDVAL;
  logic [9:0]  iDATA;
  logic        iSTART;
  logic        iABORT;
  logic        oBUSY;
  logic        oDONE;
  logic        oFOUND;
  logic [15:0] oXSTART;
  logic [15:0] oXEND;
  logic [15:0] oYSTART;
  logic [15:0] oYEND;
  logic [7:0]  oFRAME_CNT;

  modport master (
    output iDVAL, iDATA, iSTART, iABORT,
    input  oBUSY, oDONE, oFOUND, oXSTART, oXEND, oYSTART, oYEND, oFRAME_CNT
  );

  modport slave (
    input  iDVAL, iDATA, iSTART, iABORT,
    output oBUSY, oDONE, oFOUND, oXSTART, oXEND, oYSTART, oYEND, oFRAME_CNT
  );
endinterface

// File: rtl/crop_window_ctrl.sv
// Multi-frame dark-pixel bounding-box measurement inside a fixed ROI, with start/abort control.
// Optional feature macro: CROP_CTRL_MARGIN_EN pads a found box by MARGIN, clamped to the ROI.
module crop_window_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ROI_X0     = 160,
  parameter int ROI_X1     = 480,
  parameter int ROI_Y0     = 120,
  parameter int ROI_Y1     = 190,
  parameter int DARK_TH    = 0,
  parameter int NUM_FRAMES = 4,
  parameter int MARGIN     = 8
) (
  input logic iCLK,
  input logic iRST,
  crop_window_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SYNC, MEASURE, DONE} state_t;

  localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);
  localparam logic [7:0]  FRAMES = 8'(NUM_FRAMES);
  localparam logic [9:0]  DARK   = 10'(DARK_TH);
  localparam logic [1:0][15:0] ROI_LO   = {16'(ROI_Y0), 16'(ROI_X0)};
  localparam logic [1:0][15:0] ROI_HI   = {16'(ROI_Y1), 16'(ROI_X1)};
  localparam logic [1:0][15:0] ROI_LAST = {16'(ROI_Y1 - 1), 16'(ROI_X1 - 1)};

  if (NUM_FRAMES < 1 || NUM_FRAMES > 255 || MARGIN < 0) begin : g_bad_param
    $error("crop_window_ctrl: NUM_FRAMES must be 1..255 and MARGIN non-negative");
  end

  state_t      state_reg, state_next;
  logic [15:0] x_reg, y_reg;
  logic [15:0] pos [2];
  logic        found_reg, found_next, pub_found_reg;
  logic [7:0]  frame_cnt_reg, cnt_next;
  logic [15:0] min_reg [2], max_reg [2], min_next [2], max_next [2];
  logic [15:0] pub_start_reg [2], pub_end_reg [2];
  logic        clear_acc, acc_en, frame_inc, publish, busy, done;
  logic        first_pixel, last_pixel, in_roi, hit;

  assign pos[0] = x_reg;
  assign pos[1] = y_reg;
  assign first_pixel = bus.iDVAL && (x_reg == 16'd0) && (y_reg == 16'd0);
  assign last_pixel  = bus.iDVAL && (x_reg == X_LAST) && (y_reg == Y_LAST);
  assign in_roi = (x_reg >= ROI_LO[0]) && (x_reg < ROI_HI[0]) &&
                  (y_reg >= ROI_LO[1]) && (y_reg < ROI_HI[1]);

  // Free-running raster position; it keeps counting in every state so SYNC can find frame starts.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (bus.iDVAL) begin
      if (x_reg == X_LAST) begin
        x_reg <= '0;
        y_reg <= (y_reg == Y_LAST) ? 16'd0 : y_reg + 16'd1;
      end else begin
        x_reg <= x_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    clear_acc  = 1'b0;
    acc_en     = 1'b0;
    frame_inc  = 1'b0;
    publish    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.iSTART && !bus.iABORT) state_next = SYNC;
      end
      SYNC: begin
        busy = 1'b1;
        if (bus.iABORT) begin
          state_next = IDLE;
        end else if (first_pixel) begin
          state_next = MEASURE;
          clear_acc  = 1'b1;
          acc_en     = 1'b1;
        end
      end
      MEASURE: begin
        busy = 1'b1;
        if (bus.iABORT) begin
          state_next = IDLE;
        end else begin
          acc_en = bus.iDVAL;
          if (last_pixel) begin
            frame_inc = 1'b1;
            if (frame_cnt_reg + 8'd1 == FRAMES) begin
              state_next = DONE;
              publish    = 1'b1;
            end
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The final pixel is folded in combinationally so the published box is valid in the DONE cycle.
  assign hit        = acc_en && in_roi && (bus.iDATA <= DARK);
  assign found_next = (found_reg && !clear_acc) || hit;
  assign cnt_next   = (clear_acc ? 8'd0 : frame_cnt_reg) + {7'd0, frame_inc};

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      found_reg     <= 1'b0;
      frame_cnt_reg <= '0;
      pub_found_reg <= 1'b0;
    end else begin
      found_reg     <= found_next;
      frame_cnt_reg <= cnt_next;
      if (publish) pub_found_reg <= found_next;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    logic [15:0] min_base, max_base, pad_start, pad_end;

    assign min_base    = clear_acc ? 16'hFFFF : min_reg[gi];
    assign max_base    = clear_acc ? 16'h0000 : max_reg[gi];
    assign min_next[gi] = (hit && (pos[gi] < min_base)) ? pos[gi] : min_base;
    assign max_next[gi] = (hit && (pos[gi] > max_base)) ? pos[gi] : max_base;

`ifdef CROP_CTRL_MARGIN_EN
    localparam logic [16:0] PAD   = 17'(MARGIN);
    localparam logic [15:0] PAD16 = 16'(MARGIN);
    logic [16:0] lo_limit, hi_pad;
    assign lo_limit  = {1'b0, ROI_LO[gi]} + PAD;
    assign hi_pad    = {1'b0, max_next[gi]} + PAD;
    assign pad_start = ({1'b0, min_next[gi]} < lo_limit) ? ROI_LO[gi] : min_next[gi] - PAD16;
    assign pad_end   = (hi_pad > {1'b0, ROI_LAST[gi]}) ? ROI_LAST[gi] : hi_pad[15:0];
`else
    assign pad_start = min_next[gi];
    assign pad_end   = max_next[gi];
`endif

    always_ff @(posedge iCLK) begin
      if (iRST) begin
        min_reg[gi]       <= 16'hFFFF;
        max_reg[gi]       <= '0;
        pub_start_reg[gi] <= '0;
        pub_end_reg[gi]   <= '0;
      end else begin
        min_reg[gi] <= min_next[gi];
        max_reg[gi] <= max_next[gi];
        if (publish) begin
          pub_start_reg[gi] <= found_next ? pad_start : ROI_LO[gi];
          pub_end_reg[gi]   <= found_next ? pad_end   : ROI_LAST[gi];
        end
      end
    end
  end

  assign bus.oBUSY      = busy;
  assign bus.oDONE      = done;
  assign bus.oFOUND     = pub_found_reg;
  assign bus.oXSTART    = pub_start_reg[0];
  assign bus.oXEND      = pub_end_reg[0];
  assign bus.oYSTART    = pub_start_reg[1];
  assign bus.oYEND      = pub_end_reg[1];
  assign bus.oFRAME_CNT = frame_cnt_reg;

endmodule

// File: tb/tb_crop_window_ctrl.sv
// Directed bench for crop_window_ctrl on a reduced 16x12 raster with ROI x 4..11, y 3..7, two frames.
// Expected boxes are hand-computed; the CROP_CTRL_MARGIN_EN build uses the padded values (MARGIN=2).
module tb_crop_window_ctrl;
  localparam int H = 16;
  localparam int V = 12;
  localparam int FRAME = H * V;

  logic clk = 1'b0;
  logic srst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   bx = 0;
  int   by = 0;

  crop_window_ctrl_if bus ();

  crop_window_ctrl #(
    .H_ACTIVE(H), .V_ACTIVE(V),
    .ROI_X0(4), .ROI_X1(12), .ROI_Y0(3), .ROI_Y1(8),
    .DARK_TH(0), .NUM_FRAMES(2), .MARGIN(2)
  ) dut (
    .iCLK(clk),
    .iRST(srst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!srst && bus.oDONE) done_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.iDVAL = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Streams n pixels from the current raster position; listed coordinates carry dark data.
  task automatic send_pix(input int n, input int dx0, input int dy0, input int dx1, input int dy1);
    for (int i = 0; i < n; i++) begin
      if (i % 5 == 4) idle(1);
      bus.iDVAL = 1'b1;
      if ((bx == dx0 && by == dy0) || (bx == dx1 && by == dy1)) bus.iDATA = 10'd0;
      else bus.iDATA = (i % 2 == 1) ? 10'd1 : 10'd600;
      @(posedge clk);
      #1;
      bx++;
      if (bx == H) begin
        bx = 0;
        by = (by == V - 1) ? 0 : by + 1;
      end
    end
    bus.iDVAL = 1'b0;
  endtask

  task automatic pulse_start(input logic with_abort);
    bus.iSTART = 1'b1;
    bus.iABORT = with_abort;
    @(posedge clk);
    #1;
    bus.iSTART = 1'b0;
    bus.iABORT = 1'b0;
  endtask

  task automatic check_done(input string tag, input int found, input int xs, input int xe,
                            input int ys, input int ye, input int ndone);
    check({tag, "_done"}, 32'(bus.oDONE), 1);
    check({tag, "_busy"}, 32'(bus.oBUSY), 0);
    check({tag, "_found"}, 32'(bus.oFOUND), 32'(found));
    check({tag, "_xstart"}, 32'(bus.oXSTART), 32'(xs));
    check({tag, "_xend"}, 32'(bus.oXEND), 32'(xe));
    check({tag, "_ystart"}, 32'(bus.oYSTART), 32'(ys));
    check({tag, "_yend"}, 32'(bus.oYEND), 32'(ye));
    check({tag, "_frames"}, 32'(bus.oFRAME_CNT), 2);
    $display("txn %s found=%0d box x %0d..%0d y %0d..%0d", tag, bus.oFOUND,
             bus.oXSTART, bus.oXEND, bus.oYSTART, bus.oYEND);
    idle(1);
    check({tag, "_done_low"}, 32'(bus.oDONE), 0);
    check({tag, "_hold_xs"}, 32'(bus.oXSTART), 32'(xs));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'(ndone));
  endtask

  task automatic check_box(input string tag, input int xs, input int xe, input int ys, input int ye);
    check({tag, "_xstart"}, 32'(bus.oXSTART), 32'(xs));
    check({tag, "_xend"}, 32'(bus.oXEND), 32'(xe));
    check({tag, "_ystart"}, 32'(bus.oYSTART), 32'(ys));
    check({tag, "_yend"}, 32'(bus.oYEND), 32'(ye));
  endtask

  initial begin
    bus.iDVAL  = 1'b0;
    bus.iDATA  = '0;
    bus.iSTART = 1'b0;
    bus.iABORT = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;
    check("rst_busy", 32'(bus.oBUSY), 0);
    check("rst_done", 32'(bus.oDONE), 0);
    check("rst_found", 32'(bus.oFOUND), 0);
    check_box("rst", 0, 0, 0, 0);
    check("rst_frames", 32'(bus.oFRAME_CNT), 0);
    $display("txn reset released");

    // Single dark pixel in frame 1.
    pulse_start(1'b0);
    check("t1_busy", 32'(bus.oBUSY), 1);
    send_pix(FRAME, 6, 5, -1, -1);
    check("t1_mid_frames", 32'(bus.oFRAME_CNT), 1);
    send_pix(FRAME, -1, -1, -1, -1);
`ifdef CROP_CTRL_MARGIN_EN
    check_done("t1", 1, 4, 8, 3, 7, 1);
`else
    check_done("t1", 1, 6, 6, 5, 5, 1);
`endif

    // Union across frames, with darks just past the exclusive ROI edges.
    pulse_start(1'b0);
    send_pix(FRAME, 5, 4, 12, 5);
    send_pix(FRAME, 10, 6, 6, 8);
`ifdef CROP_CTRL_MARGIN_EN
    check_done("t2", 1, 4, 11, 3, 7, 2);
`else
    check_done("t2", 1, 5, 10, 4, 6, 2);
`endif

    // Inclusive ROI corners.
    pulse_start(1'b0);
    send_pix(FRAME, 4, 3, -1, -1);
    send_pix(FRAME, 11, 7, -1, -1);
    check_done("t2b", 1, 4, 11, 3, 7, 3);

    // Darks only outside the ROI: full-ROI fallback.
    pulse_start(1'b0);
    send_pix(FRAME, 4, 8, -1, -1);
    send_pix(FRAME, 3, 5, 0, 0);
    check_done("t3", 0, 4, 11, 3, 7, 4);

    // Start mid-frame at (9,1); the rest of that frame is not measured.
    send_pix(25, -1, -1, -1, -1);
    pulse_start(1'b0);
    check("t4_busy", 32'(bus.oBUSY), 1);
    send_pix(FRAME - 25, 5, 4, -1, -1);
    check("t4_still_busy", 32'(bus.oBUSY), 1);
    send_pix(FRAME, 8, 6, -1, -1);
    send_pix(FRAME, -1, -1, -1, -1);
`ifdef CROP_CTRL_MARGIN_EN
    check_done("t4", 1, 6, 10, 4, 7, 5);
`else
    check_done("t4", 1, 8, 8, 6, 6, 5);
`endif

    // Abort during frame 2; prior result must be retained.
    pulse_start(1'b0);
    send_pix(FRAME, 7, 7, -1, -1);
    send_pix(50, -1, -1, -1, -1);
    bus.iABORT = 1'b1;
    @(posedge clk);
    #1;
    bus.iABORT = 1'b0;
    check("t5_abort_busy", 32'(bus.oBUSY), 0);
    send_pix(FRAME - 50, -1, -1, -1, -1);
    check("t5_no_done", 32'(done_cnt), 5);
`ifdef CROP_CTRL_MARGIN_EN
    check_box("t5_retain", 6, 10, 4, 7);
`else
    check_box("t5_retain", 8, 8, 6, 6);
`endif
    pulse_start(1'b1);
    check("t5_start_abort_busy", 32'(bus.oBUSY), 0);
    send_pix(FRAME, 6, 6, -1, -1);
    check("t5_idle_busy", 32'(bus.oBUSY), 0);
    check("t5_idle_no_done", 32'(done_cnt), 5);
    $display("txn abort sequence complete");

    // Reset in MEASURE, then a clean run.
    pulse_start(1'b0);
    send_pix(30, 5, 5, -1, -1);
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    bx = 0;
    by = 0;
    check("t6_rst_busy", 32'(bus.oBUSY), 0);
    check("t6_rst_found", 32'(bus.oFOUND), 0);
    check_box("t6_rst", 0, 0, 0, 0);
    check("t6_rst_frames", 32'(bus.oFRAME_CNT), 0);
    pulse_start(1'b0);
    send_pix(FRAME, -1, -1, -1, -1);
    send_pix(FRAME, 9, 4, -1, -1);
`ifdef CROP_CTRL_MARGIN_EN
    check_done("t6", 1, 7, 11, 3, 6, 6);
`else
    check_done("t6", 1, 9, 9, 4, 4, 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
